traffic_fsm: RTL and testbench
==============================

Name: traffic_fsm

Overview:
- Timing/sequencing stage directly upstream of the lamp decoder.
- Generates the 2-bit phase code (00 red, 01 green, 10 yellow, 11 all-off) and the green-blink flag that the decoder turns into lamp drives.
- Also exports the remaining seconds of the current phase for the countdown display.
- Contains its own 1 Hz prescaler and the phase state machine.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per second (>=2, even).
- RED_T, 30, red phase length in seconds (>=1).
- GREEN_T, 27, green phase length in seconds; includes the blink tail.
- BLINK_T, 3, final seconds of green during which blink is active (1 <= BLINK_T < GREEN_T).
- YELLOW_T, 3, yellow phase length in seconds (>=1).
- CNT_W, 8, width of remain; must hold the largest of the phase lengths.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; 0 freezes sequencing.
- state  output  2  phase code to the lamp decoder.
- blink  output  1  1 = green lamp dark this half-second.
- remain  output  CNT_W  seconds left in the current phase, counting N..1.
- sec_tick  output  1  one-clk pulse at each second boundary while en=1.
- night  input  1  present only when TRAFFIC_NIGHT_EN is defined.

Interface (already decided): one clock, clk; reset rst_n, asynchronous, active-low. All outputs are registered.

Behaviour:
- Reset values: state=00, remain=RED_T, blink=0, sec_tick=0, div_cnt=0.
- Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps, advancing only while en=1.
  - tick is the cycle where div_cnt==TICK_DIV-1 and en=1.
  - sec_tick is asserted in the clock cycle following the tick, aligned with the remain update.
  - second_half is true when div_cnt >= TICK_DIV/2.
- Phase FSM transitions: RED(00) -> GREEN(01) -> YELLOW(10) -> RED, forever.
- On a tick:
  - If remain==1: advance to the next phase and load that phase's duration (GREEN_T, YELLOW_T or RED_T) into remain.
  - Otherwise: decrement remain.
  - remain is never 0 in normal operation.
- Phase lengths in clk cycles: RED_T*TICK_DIV, GREEN_T*TICK_DIV, YELLOW_T*TICK_DIV.
- blink (registered) = (state==01) & (remain<=BLINK_T) & second_half & en.
  - Result: the green lamp is lit for the first half and dark for the second half of each tail second.
  - blink is 0 in every other phase.
- en=0:
  - div_cnt, remain and state hold.
  - blink is forced to 0, so the lamp shows solid.
  - sec_tick stays 0.
  - On resume, counting continues from the held div_cnt; no phase is restarted.
- Reset mid-phase: immediate asynchronous return to the reset values; restart at a full red phase.
- Code 11 is never produced without the optional feature. If an illegal state is reached, recover to RED with remain=RED_T on the next clk.

Optional Feature:
- Macro: TRAFFIC_NIGHT_EN.
- Defined: the night input exists.
  - night=1 overrides the FSM: the state output alternates 10 (first half of each second) and 11 (second half), giving a flashing yellow. blink=0 and remain holds its value.
  - On night 1->0: enter RED with remain=RED_T and div_cnt=0.
  - night is sampled synchronously and takes priority over en.
- Undefined: no night port; state is never 11.

Decomposition:
- Package traffic_pkg holds:
  - localparams for the phase codes: PH_RED=2'b00, PH_GREEN=2'b01, PH_YELLOW=2'b10, PH_OFF=2'b11.
  - The default durations, shared with the lamp decoder and the display driver.
- One sub-module: tick_divider (div_cnt, tick, second_half; parameter TICK_DIV; ports clk, rst_n, en).
- The FSM and remain counter stay in traffic_fsm.

Test Plan (TICK_DIV=4, RED_T=3, GREEN_T=4, BLINK_T=2, YELLOW_T=2, en=1):
- Reset release -> state=00 and remain=3; first sec_tick 4 clks after release, remain=2; state=01 with remain=4 exactly 12 clks after release.
- Full cycle -> state sequence 00(12 clks), 01(16), 10(8), 00; period 36 clks, repeating for 3 cycles.
- Green tail -> blink=0 while remain=4,3; for remain=2,1, blink=0 for 2 clks then 1 for 2 clks per second; blink=0 throughout red and yellow.
- en=0 for 10 clks mid-green with remain=2 -> state, remain and div_cnt frozen, blink=0; after re-enable the phase completes with the original remaining clk count.
- rst_n pulsed low during yellow -> outputs immediately 00/3/0 with no clk edge; sequence then restarts as in the first scenario.
- TRAFFIC_NIGHT_EN, night=1 in green -> state toggles 10/11 every 2 clks; after night=0, state=00, remain=3, and a 12-clk red phase follows.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase codes and default durations shared with the lamp decoder and display driver
package traffic_pkg;

  localparam logic [1:0] PH_RED    = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_YELLOW = 2'b10;
  localparam logic [1:0] PH_OFF    = 2'b11;

  localparam int DEF_TICK_DIV = 50_000_000;
  localparam int DEF_RED_T    = 30;
  localparam int DEF_GREEN_T  = 27;
  localparam int DEF_BLINK_T  = 3;
  localparam int DEF_YELLOW_T = 3;
  localparam int DEF_CNT_W    = 8;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_YELLOW;
      default:  return PH_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_fsm_tick_divider.sv
// rtl/traffic_fsm_tick_divider.sv - 1 Hz prescaler: div_cnt, tick and second_half
module tick_divider
  import traffic_pkg::*;
#(
  parameter  int TICK_DIV = DEF_TICK_DIV,
  localparam int DIV_W    = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [DIV_W-1:0] div_cnt,
  output logic             tick,
  output logic             second_half
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(TICK_DIV / 2);

  assign tick        = en && (div_cnt == LAST);
  assign second_half = (div_cnt >= HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// rtl/traffic_fsm.sv - phase sequencer with per-phase countdown and green-tail blink
// Optional flashing-yellow night mode via TRAFFIC_NIGHT_EN.
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int RED_T    = DEF_RED_T,
  parameter int GREEN_T  = DEF_GREEN_T,
  parameter int BLINK_T  = DEF_BLINK_T,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef TRAFFIC_NIGHT_EN
  input  logic             night,
`endif
  output logic [1:0]       state,
  output logic             blink,
  output logic [CNT_W-1:0] remain,
  output logic             sec_tick
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             tick_run;
  logic             second_half;
  logic             night_on;
  logic             night_exit;
  logic             run;
  logic             fsm_tick;
  logic             half_nx;
  logic             blink_d;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] remain_nx;

`ifdef TRAFFIC_NIGHT_EN
  logic night_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) night_q <= 1'b0;
    else        night_q <= night;
  end

  assign night_on   = night;
  assign night_exit = night_q && !night;
`else
  assign night_on   = 1'b0;
  assign night_exit = 1'b0;
`endif

  // Night flashing needs the prescaler running even when en is low.
  assign run      = en || night_on;
  assign fsm_tick = tick_run && !night_on && !night_exit;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (run),
    .clr         (night_exit),
    .div_cnt     (div_cnt),
    .tick        (tick_run),
    .second_half (second_half)
  );

  // Registered outputs are computed from post-edge values so blink lines up with remain.
  assign half_nx = night_exit ? 1'b0 :
                   !run       ? second_half :
                   (!tick_run && (second_half || div_cnt == DIV_W'(TICK_DIV / 2 - 1)));

  function automatic logic [CNT_W-1:0] phase_len(input logic [1:0] ph);
    case (ph)
      PH_GREEN:  return CNT_W'(GREEN_T);
      PH_YELLOW: return CNT_W'(YELLOW_T);
      default:   return CNT_W'(RED_T);
    endcase
  endfunction

  always_comb begin
    state_nx  = state;
    remain_nx = remain;
    if (night_exit) begin
      state_nx  = PH_RED;
      remain_nx = CNT_W'(RED_T);
    end else if (night_on) begin
      state_nx = half_nx ? PH_OFF : PH_YELLOW;
    end else if (state == PH_OFF) begin
      state_nx  = PH_RED;
      remain_nx = CNT_W'(RED_T);
    end else if (fsm_tick) begin
      if (remain <= CNT_W'(1)) begin
        state_nx  = next_phase(state);
        remain_nx = phase_len(next_phase(state));
      end else begin
        remain_nx = remain - CNT_W'(1);
      end
    end
  end

  assign blink_d = en && !night_on && (state_nx == PH_GREEN) &&
                   (remain_nx <= CNT_W'(BLINK_T)) && half_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PH_RED;
      remain   <= CNT_W'(RED_T);
      blink    <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      state    <= state_nx;
      remain   <= remain_nx;
      blink    <= blink_d;
      sec_tick <= fsm_tick;
    end
  end

endmodule

// File: tb/tb_traffic_fsm.sv
// tb/tb_traffic_fsm.sv - randomized bench for traffic_fsm against an elapsed-time reference model
module tb_traffic_fsm;

  localparam int D   = 4;
  localparam int R   = 3;
  localparam int G   = 4;
  localparam int B   = 2;
  localparam int Y   = 2;
  localparam int PER = (R + G + Y) * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
`ifdef TRAFFIC_NIGHT_EN
  logic       night = 1'b0;
`endif
  logic [1:0] state;
  logic       blink;
  logic [7:0] remain;
  logic       sec_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase, countdown and blink follow from the number of enabled clocks since reset.
  int         t_en = 0;
  logic [1:0] m_state;
  int         m_remain;
  logic       m_blink;
  logic       m_sec;

  traffic_fsm #(
    .TICK_DIV(D), .RED_T(R), .GREEN_T(G), .BLINK_T(B), .YELLOW_T(Y), .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
`ifdef TRAFFIC_NIGHT_EN
    .night    (night),
`endif
    .state    (state),
    .blink    (blink),
    .remain   (remain),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    int pos;
    pos = t_en % PER;
    if (pos < R * D) begin
      m_state = 2'b00; m_remain = R - pos / D;
    end else if (pos < (R + G) * D) begin
      m_state = 2'b01; m_remain = G - (pos - R * D) / D;
    end else begin
      m_state = 2'b10; m_remain = Y - (pos - (R + G) * D) / D;
    end
  endtask

  task automatic step();
    logic e;
    @(posedge clk);
    e = en;
    if (e) t_en++;
    model_eval();
    m_sec   = e && (t_en % D == 0);
    m_blink = e && (m_state == 2'b01) && (m_remain <= B) && ((t_en % D) >= D / 2);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got %b want 00", state); end
    n_cmp++; if (remain !== 8'd3) begin n_bad++; $display("FAIL reset_remain got %0d want 3", remain); end
    n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL reset_blink got %b want 0", blink); end
    n_cmp++; if (sec_tick !== 1'b0) begin n_bad++; $display("FAIL reset_sec_tick got %b want 0", sec_tick); end
    @(negedge clk); rst_n = 1'b1; t_en = 0;
  endtask

  task automatic test_startup(input string tag);
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++;
      if (sec_tick !== (i % 4 == 0)) begin
        n_bad++; $display("FAIL %s_sec_tick clk %0d got %b want %b", tag, i, sec_tick, (i % 4 == 0));
      end
      if (i == 4) begin
        n_cmp++; if (remain !== 8'd2) begin n_bad++; $display("FAIL %s_first_sec remain got %0d want 2", tag, remain); end
      end
      if (i < 12) begin
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL %s_red clk %0d got %b want 00", tag, i, state); end
      end else begin
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL %s_green_at_12 got %b want 01", tag, state); end
        n_cmp++; if (remain !== 8'd4) begin n_bad++; $display("FAIL %s_green_remain got %0d want 4", tag, remain); end
      end
    end
  endtask

  task automatic test_full_cycle();
    logic [1:0] prev;
    int seg_start, len, want;
    prev = 2'b01; seg_start = t_en;
    for (int k = 0; k < 3 * PER; k++) begin
      step();
      n_cmp++; if (state !== m_state) begin n_bad++; $display("FAIL cycle_state t=%0d got %b want %b", t_en, state, m_state); end
      n_cmp++; if (remain !== 8'(m_remain)) begin n_bad++; $display("FAIL cycle_remain t=%0d got %0d want %0d", t_en, remain, m_remain); end
      n_cmp++; if (blink !== m_blink) begin n_bad++; $display("FAIL cycle_blink t=%0d got %b want %b", t_en, blink, m_blink); end
      n_cmp++; if (sec_tick !== m_sec) begin n_bad++; $display("FAIL cycle_sec_tick t=%0d got %b want %b", t_en, sec_tick, m_sec); end
      if (state !== prev) begin
        len  = t_en - seg_start;
        want = (prev == 2'b00) ? 12 : (prev == 2'b01) ? 16 : 8;
        n_cmp++; if (len != want) begin n_bad++; $display("FAIL phase_len %b got %0d want %0d", prev, len, want); end
        prev = state; seg_start = t_en;
      end
    end
  endtask

  task automatic test_green_tail();
    int ones[5];
    int guard;
    foreach (ones[i]) ones[i] = 0;
    guard = 0;
    while (!(m_state == 2'b01 && (t_en % PER) == R * D) && guard < 2 * PER) begin step(); guard++; end
    n_cmp++; if (guard >= 2 * PER) begin n_bad++; $display("FAIL tail_sync timeout got %0d want <%0d", guard, 2 * PER); end
    for (int k = 0; k < G * D; k++) begin
      if (m_remain >= 1 && m_remain <= 4 && blink === 1'b1) ones[m_remain]++;
      n_cmp++; if (blink !== m_blink) begin n_bad++; $display("FAIL tail_blink rem=%0d got %b want %b", m_remain, blink, m_blink); end
      step();
    end
    for (int r = 1; r <= 4; r++) begin
      n_cmp++;
      if (ones[r] != ((r <= B) ? D / 2 : 0)) begin
        n_bad++; $display("FAIL tail_ones rem=%0d got %0d want %0d", r, ones[r], (r <= B) ? D / 2 : 0);
      end
    end
  endtask

  task automatic test_en_freeze();
    int guard, rem_clks, cnt;
    guard = 0;
    while (!(m_state == 2'b01 && m_remain == 2 && (t_en % D) == 1) && guard < 2 * PER) begin step(); guard++; end
    n_cmp++; if (guard >= 2 * PER) begin n_bad++; $display("FAIL freeze_sync timeout got %0d want <%0d", guard, 2 * PER); end
    rem_clks = (R + G) * D - (t_en % PER);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL freeze_state got %b want 01", state); end
      n_cmp++; if (remain !== 8'd2) begin n_bad++; $display("FAIL freeze_remain got %0d want 2", remain); end
      n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL freeze_blink got %b want 0", blink); end
      n_cmp++; if (sec_tick !== 1'b0) begin n_bad++; $display("FAIL freeze_sec_tick got %b want 0", sec_tick); end
    end
    en = 1'b1; cnt = 0;
    while (state !== 2'b10 && cnt < 100) begin step(); cnt++; end
    n_cmp++; if (cnt != rem_clks) begin n_bad++; $display("FAIL freeze_resume clks got %0d want %0d", cnt, rem_clks); end
  endtask

  task automatic test_reset_mid_yellow();
    int guard;
    guard = 0;
    while (m_state != 2'b10 && guard < 2 * PER) begin step(); guard++; end
    step();
    n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL midrst_in_yellow got %b want 10", state); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL midrst_state got %b want 00", state); end
    n_cmp++; if (remain !== 8'd3) begin n_bad++; $display("FAIL midrst_remain got %0d want 3", remain); end
    n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL midrst_blink got %b want 0", blink); end
    @(negedge clk); rst_n = 1'b1; t_en = 0;
    test_startup("restart");
  endtask

  task automatic test_random_en();
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      step();
      n_cmp++; if (state !== m_state) begin n_bad++; $display("FAIL rand_state t=%0d got %b want %b", t_en, state, m_state); end
      n_cmp++; if (remain !== 8'(m_remain)) begin n_bad++; $display("FAIL rand_remain t=%0d got %0d want %0d", t_en, remain, m_remain); end
      n_cmp++; if (blink !== m_blink) begin n_bad++; $display("FAIL rand_blink t=%0d got %b want %b", t_en, blink, m_blink); end
      n_cmp++; if (sec_tick !== m_sec) begin n_bad++; $display("FAIL rand_sec_tick t=%0d got %b want %b", t_en, sec_tick, m_sec); end
    end
    en = 1'b1;
  endtask

`ifdef TRAFFIC_NIGHT_EN
  task automatic test_night();
    int guard, nd, held;
    logic [1:0] want;
    guard = 0;
    while (m_state != 2'b01 && guard < 2 * PER) begin step(); guard++; end
    nd = t_en % D; held = m_remain;
    night = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      nd = (nd + 1) % D;
      want = (nd >= D / 2) ? 2'b11 : 2'b10;
      n_cmp++; if (state !== want) begin n_bad++; $display("FAIL night_state got %b want %b", state, want); end
      n_cmp++; if (remain !== 8'(held)) begin n_bad++; $display("FAIL night_remain got %0d want %0d", remain, held); end
      n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL night_blink got %b want 0", blink); end
    end
    night = 1'b0;
    @(posedge clk); #1;
    t_en = 0; model_eval();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL night_exit_state got %b want 00", state); end
    n_cmp++; if (remain !== 8'd3) begin n_bad++; $display("FAIL night_exit_remain got %0d want 3", remain); end
    test_startup("night_exit");
  endtask
`endif

  initial begin
    test_reset();
    test_startup("start");
    test_full_cycle();
    test_green_tail();
    test_en_freeze();
    test_reset_mid_yellow();
    test_random_en();
`ifdef TRAFFIC_NIGHT_EN
    test_night();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
